// File: rtl/tick_stopwatch.sv
// Two-digit BCD stopwatch advanced by rising edges of a divided square wave,
// under an IDLE/RUN/PAUSE run-control FSM with synchronous clear.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   div_in   in   divided square wave (same clock domain)
//   start    in   run request (level sampled)
//   stop     in   pause request (level sampled)
//   clear    in   synchronous clear to 00 / IDLE
//   count_lo out  BCD low digit
//   count_hi out  BCD high digit
//   running  out  high while in RUN
//   wrap     out  one-cycle pulse after rollover to 00
module tick_stopwatch #(
    parameter int LO_MAX = 9,
    parameter int HI_MAX = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       div_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] count_lo,
    output logic [3:0] count_hi,
    output logic       running,
    output logic       wrap
);

    localparam logic [3:0] LO_M = 4'(LO_MAX);
    localparam logic [3:0] HI_M = 4'(HI_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       div_prev_q;
    logic [3:0] lo_q, lo_d;
    logic [3:0] hi_q, hi_d;
    logic       wrap_q, wrap_d;
    logic       tick;

    // A high level of any length yields one tick; edges seen outside RUN
    // are simply dropped because div_prev_q tracks div_in in every state.
    assign tick = div_in & ~div_prev_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start and stop together hold the state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start && !stop) state_d = RUN;
                RUN:     if (stop && !start) state_d = PAUSE;
                PAUSE:   if (start && !stop) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        running = (state_q == RUN);
    end

    // Digit arithmetic keyed on the pre-transition state, so a tick that
    // arrives with stop still counts while one arriving with start does not.
    always_comb begin
        lo_d   = lo_q;
        hi_d   = hi_q;
        wrap_d = 1'b0;
        if (clear) begin
            lo_d = 4'd0;
            hi_d = 4'd0;
        end else if (state_q == RUN && tick) begin
            if (lo_q < LO_M) begin
                lo_d = lo_q + 4'd1;
            end else begin
                lo_d = 4'd0;
                if (hi_q < HI_M) begin
                    hi_d = hi_q + 4'd1;
                end else begin
                    hi_d   = 4'd0;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_prev_q <= 1'b0;
            lo_q       <= 4'd0;
            hi_q       <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            div_prev_q <= div_in;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            wrap_q     <= wrap_d;
        end
    end

    assign count_lo = lo_q;
    assign count_hi = hi_q;
    assign wrap     = wrap_q;

endmodule
